alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
- Command-driven initiator for the board ALU datapath, taking the place of the manual switch/key operand loading.
- Accepts a packed command (x, y, shamt, op) on a valid/ready port and sequences it onto the shared operand bus with load_x then load_y strobes into the external x/y registers.
- Waits a fixed settle time, captures the ALU result and zero flag, and returns them on a valid/ready response port.
- Sits between a host-side command source (UART/test controller) and the x/y register pair plus alu instance.

Parameters:
- WIDTH, 4, operand and result width.
- SHIFT, 2, shift-amount field width.
- SETTLE, 2, cycles from the end of the load_y strobe to result capture; legal range 1..15.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_x  in  WIDTH  x operand.
- cmd_y  in  WIDTH  y operand.
- cmd_shamt  in  SHIFT  shift amount.
- cmd_op  in  2  ALU operation select.
- data_bus  out  WIDTH  operand bus to the x/y register data_in.
- load_x  out  1  x register load strobe.
- load_y  out  1  y register load strobe.
- shamt  out  SHIFT  to ALU shamt.
- operation  out  2  to ALU operation.
- alu_result  in  WIDTH  ALU result (combinational from the registers).
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  WIDTH  captured result.
- rsp_zero  out  1  captured zero flag.
- busy  out  1  high in any state other than IDLE.
- cmd_count  out  8  completed responses, wraps modulo 256.

Behaviour:
- Reset:
  - Synchronous, active-high; takes priority over all other inputs.
  - On the edge where reset is high: state goes to IDLE, and all registered outputs clear (data_bus, shamt, operation, rsp_result, rsp_zero and cmd_count become 0).
  - cmd_ready = (state==IDLE) & ~reset, so it is 0 while reset is high.
  - load_x, load_y, rsp_valid and busy are 0 from the first reset edge.
- Outputs:
  - All outputs are registered or decoded from the state register only.
  - There is no combinational path from cmd_* or rsp_ready to any output.
- FSM states: IDLE, LOAD_X, LOAD_Y, SETTLE, RESPOND.
- IDLE:
  - cmd_ready=1, data_bus=0.
  - On cmd_valid: latch x, y, shamt and op into internal registers and go to LOAD_X.
  - shamt and operation outputs update from the latched values and hold until the next accept.
- LOAD_X (1 cycle): data_bus=latched x, load_x=1; then go to LOAD_Y.
- LOAD_Y (1 cycle): data_bus=latched y, load_y=1; load the settle counter with SETTLE-1; then go to SETTLE.
- SETTLE:
  - data_bus holds y, no strobes.
  - The counter decrements each cycle.
  - In the cycle where the counter is 0: capture alu_result and alu_zero into rsp_result and rsp_zero, then go to RESPOND.
- RESPOND:
  - rsp_valid=1; rsp_result and rsp_zero are held stable until rsp_valid & rsp_ready.
  - On that handshake: cmd_count increments, then go to IDLE.
- Load strobe rules: load_x and load_y are never high together; each is exactly 1 cycle per command.
- Latency: command accepted at edge T gives
  - load_x during cycle T+1;
  - load_y during cycle T+2;
  - capture at the end of cycle T+2+SETTLE;
  - rsp_valid from cycle T+3+SETTLE.
- Throughput:
  - No overlap: a new command is accepted only in IDLE.
  - Minimum period is 4+SETTLE cycles (6 at defaults) with rsp_ready held high.
- Operand stability: changes on cmd_* after the accept have no effect on the command in flight.
- Backpressure: rsp_ready low holds RESPOND indefinitely; cmd_valid is ignored throughout.
- Reset mid-operation: any state returns to IDLE on the next edge. The in-flight command is discarded, no rsp_valid is produced and cmd_count is unchanged (cleared to 0 by the reset itself).
- Counter wrap: cmd_count goes from 255 to 0 on the next completion.

Test Plan:
- The bench instantiates two WIDTH-wide registers (loaded by load_x/load_y) plus an ALU model; for op 0 the model gives result = (x+y) mod 16 and zero = (result==0).
- Reset: hold reset 2 cycles mid-traffic -> all outputs 0 and cmd_ready 0 while reset is high; cmd_ready=1 on the first cycle after release.
- Single command x=3, y=5, op=0, shamt=1, SETTLE=2, accepted at T:
  - data_bus=3 with load_x at T+1;
  - data_bus=5 with load_y at T+2;
  - rsp_valid at T+5 with rsp_result=8, rsp_zero=0, shamt=1, operation=0;
  - rsp_ready=1 -> cmd_count=1.
- Backpressure: x=9, y=7, op=0 with rsp_ready low for 10 cycles:
  - rsp_valid stays high, rsp_result=0 and rsp_zero=1 stay stable, cmd_ready=0;
  - a new cmd_valid is ignored;
  - rsp_ready high -> IDLE, cmd_count increments by 1.
- Back-to-back: cmd_valid held with 3 commands (1+1, 2+2, 15+1) and rsp_ready=1 -> responses 2, 4, 0 (zero=1) in order, accepts 6 cycles apart, cmd_count=3. Changing cmd_x right after each accept does not alter results.
- Reset mid-operation: reset asserted in the SETTLE state -> IDLE next cycle, no rsp_valid ever appears for that command, cmd_count=0.
- Wrap: 256 completed commands -> cmd_count reads 255 after the 255th and 0 after the 256th.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// Command-driven operand sequencer for the board ALU: strobes x then y onto the
// shared operand bus, waits for the ALU to settle, and returns the captured result.
module alu_operand_sequencer #(
    parameter int WIDTH  = 4,
    parameter int SHIFT  = 2,
    parameter int SETTLE = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_x,
    input  logic [WIDTH-1:0] cmd_y,
    input  logic [SHIFT-1:0] cmd_shamt,
    input  logic [1:0]       cmd_op,
    output logic [WIDTH-1:0] data_bus,
    output logic             load_x,
    output logic             load_y,
    output logic [SHIFT-1:0] shamt,
    output logic [1:0]       operation,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             busy,
    output logic [7:0]       cmd_count
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_X  = 3'd1;
    localparam logic [2:0] S_LOAD_Y  = 3'd2;
    localparam logic [2:0] S_SETTLE  = 3'd3;
    localparam logic [2:0] S_RESPOND = 3'd4;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE - 1);

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_data_bus;
    logic [WIDTH-1:0] r_y;
    logic [SHIFT-1:0] r_shamt;
    logic [1:0]       r_op;
    logic [3:0]       r_cnt;
    logic [WIDTH-1:0] r_rsp_result;
    logic             r_rsp_zero;
    logic [7:0]       r_cmd_count;

    logic w_idle;

    // The bus register doubles as the x latch: it is loaded with x on accept and
    // only moves to y once the x strobe cycle is over, so no separate x copy is kept.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_data_bus   <= '0;
            r_y          <= '0;
            r_shamt      <= '0;
            r_op         <= '0;
            r_cnt        <= '0;
            r_rsp_result <= '0;
            r_rsp_zero   <= 1'b0;
            r_cmd_count  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_data_bus <= cmd_x;
                        r_y        <= cmd_y;
                        r_shamt    <= cmd_shamt;
                        r_op       <= cmd_op;
                        r_state    <= S_LOAD_X;
                    end
                end
                S_LOAD_X: begin
                    r_data_bus <= r_y;
                    r_state    <= S_LOAD_Y;
                end
                S_LOAD_Y: begin
                    r_cnt   <= SETTLE_INIT;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (r_cnt == 4'd0) begin
                        r_rsp_result <= alu_result;
                        r_rsp_zero   <= alu_zero;
                        r_state      <= S_RESPOND;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESPOND: begin
                    if (rsp_ready) begin
                        r_cmd_count <= r_cmd_count + 8'd1;
                        r_data_bus  <= '0;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_data_bus <= '0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // Everything below decodes only the state register, plus reset gating cmd_ready.
    assign w_idle     = (r_state == S_IDLE);
    assign cmd_ready  = w_idle & ~reset;
    assign load_x     = (r_state == S_LOAD_X);
    assign load_y     = (r_state == S_LOAD_Y);
    assign rsp_valid  = (r_state == S_RESPOND);
    assign busy       = ~w_idle;
    assign data_bus   = r_data_bus;
    assign shamt      = r_shamt;
    assign operation  = r_op;
    assign rsp_result = r_rsp_result;
    assign rsp_zero   = r_rsp_zero;
    assign cmd_count  = r_cmd_count;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed + randomized bench for alu_operand_sequencer with external x/y registers,
// an ALU stand-in, and a command-level reference for results and completion count.
module tb_alu_operand_sequencer;

    localparam int WIDTH  = 4;
    localparam int SHIFT  = 2;
    localparam int SETTLE = 2;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_x = '0;
    logic [WIDTH-1:0] cmd_y = '0;
    logic [SHIFT-1:0] cmd_shamt = '0;
    logic [1:0]       cmd_op = '0;
    logic [WIDTH-1:0] data_bus;
    logic             load_x;
    logic             load_y;
    logic [SHIFT-1:0] shamt;
    logic [1:0]       operation;
    logic [WIDTH-1:0] alu_result;
    logic             alu_zero;
    logic             rsp_valid;
    logic             rsp_ready = 1'b0;
    logic [WIDTH-1:0] rsp_result;
    logic             rsp_zero;
    logic             busy;
    logic [7:0]       cmd_count;

    int nChecks = 0;
    int nPass = 0;
    int cyc = 0;
    int expCount = 0;
    int lastAccept = 0;

    logic [WIDTH-1:0] regX;
    logic [WIDTH-1:0] regY;

    alu_operand_sequencer #(.WIDTH(WIDTH), .SHIFT(SHIFT), .SETTLE(SETTLE)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_shamt(cmd_shamt), .cmd_op(cmd_op),
        .data_bus(data_bus), .load_x(load_x), .load_y(load_y),
        .shamt(shamt), .operation(operation),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero),
        .busy(busy), .cmd_count(cmd_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Board-side x/y register pair feeding a combinational ALU.
    always @(posedge clock) begin
        if (load_x) regX <= data_bus;
        if (load_y) regY <= data_bus;
    end

    always_comb begin
        alu_result = '0;
        case (operation)
            2'd0:    alu_result = regX + regY;
            2'd1:    alu_result = regX - regY;
            2'd2:    alu_result = regX & regY;
            default: alu_result = regX << shamt;
        endcase
        alu_zero = (alu_result == '0);
    end

    function automatic logic [WIDTH-1:0] refAlu(input int op, input int x, input int y, input int sh);
        int r;
        case (op)
            0:       r = x + y;
            1:       r = x - y;
            2:       r = x & y;
            default: r = x << sh;
        endcase
        return r[WIDTH-1:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks = nChecks + 1;
        assert (obs === exp) nPass = nPass + 1;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput(tag, 32'({data_bus, load_x, load_y, shamt, operation, rsp_valid,
                              rsp_result, rsp_zero, busy, cmd_count, cmd_ready}), 32'd0);
    endtask

    // One full command: accept, x/y strobes, settle, response held for 'hold' cycles.
    // cmd_valid stays high with scrambled operands until the handshake.
    task automatic applyStimulus(input int x, input int y, input int sh, input int op,
                                 input int hold, input bit checkGap);
        logic [WIDTH-1:0] expR;
        expR = refAlu(op, x, y, sh);
        checkOutput("idle_ready", 32'(cmd_ready), 32'd1);
        if (checkGap) checkOutput("accept_gap", 32'(cyc - lastAccept), 32'(4 + SETTLE));
        lastAccept = cyc;
        cmd_valid = 1'b1;
        cmd_x = WIDTH'(x);
        cmd_y = WIDTH'(y);
        cmd_shamt = SHIFT'(sh);
        cmd_op = 2'(op);
        rsp_ready = 1'b0;
        step();
        cmd_x = WIDTH'($urandom);
        cmd_y = WIDTH'($urandom);
        cmd_shamt = SHIFT'($urandom);
        cmd_op = 2'($urandom);
        checkOutput("lx_strobes", 32'({load_x, load_y, busy, cmd_ready, rsp_valid}), 32'b10100);
        checkOutput("lx_bus", 32'(data_bus), 32'(x));
        checkOutput("lx_ctrl", 32'({shamt, operation}), 32'({SHIFT'(sh), 2'(op)}));
        step();
        checkOutput("ly_strobes", 32'({load_x, load_y, busy, cmd_ready, rsp_valid}), 32'b01100);
        checkOutput("ly_bus", 32'(data_bus), 32'(y));
        for (int i = 0; i < SETTLE; i++) begin
            step();
            checkOutput("settle_strobes", 32'({load_x, load_y, busy, cmd_ready, rsp_valid}), 32'b00100);
            checkOutput("settle_bus", 32'(data_bus), 32'(y));
        end
        for (int i = 0; i <= hold; i++) begin
            step();
            checkOutput("rsp_valid", 32'({rsp_valid, cmd_ready, busy}), 32'b101);
            checkOutput("rsp_result", 32'(rsp_result), 32'(expR));
            checkOutput("rsp_zero", 32'(rsp_zero), 32'(expR == '0));
            checkOutput("rsp_ctrl", 32'({shamt, operation}), 32'({SHIFT'(sh), 2'(op)}));
            checkOutput("rsp_count", 32'(cmd_count), 32'(expCount));
            if (i == hold) rsp_ready = 1'b1;
        end
        expCount = (expCount + 1) % 256;
        step();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        checkOutput("done_state", 32'({rsp_valid, busy, cmd_ready, load_x, load_y}), 32'b00100);
        checkOutput("done_bus", 32'(data_bus), 32'd0);
        checkOutput("done_count", 32'(cmd_count), 32'(expCount));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1;
        step();
        checkResetOutputs("reset_c1");
        step();
        checkResetOutputs("reset_c2");
        reset = 1'b0;
        #1;
        checkOutput("ready_after_reset", 32'({cmd_ready, busy}), 32'b10);
        step();

        applyStimulus(3, 5, 1, 0, 0, 1'b0);
        checkOutput("single_count", 32'(cmd_count), 32'd1);

        applyStimulus(9, 7, 2, 0, 10, 1'b0);
        checkOutput("bp_count", 32'(cmd_count), 32'd2);

        // Abort a command in SETTLE with a 2-cycle reset.
        cmd_valid = 1'b1;
        cmd_x = 4'd4;
        cmd_y = 4'd4;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        checkOutput("abort_busy", 32'({busy, load_x, load_y, rsp_valid}), 32'b1000);
        reset = 1'b1;
        step();
        checkResetOutputs("abort_rst_c1");
        step();
        checkResetOutputs("abort_rst_c2");
        reset = 1'b0;
        expCount = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            checkOutput("abort_quiet", 32'({rsp_valid, busy, cmd_count}), 32'd0);
        end

        applyStimulus(1, 1, 0, 0, 0, 1'b0);
        applyStimulus(2, 2, 0, 0, 0, 1'b1);
        applyStimulus(15, 1, 0, 0, 0, 1'b1);
        checkOutput("b2b_count", 32'(cmd_count), 32'd3);

        reset = 1'b1;
        step();
        reset = 1'b0;
        expCount = 0;
        step();
        for (int i = 0; i < 256; i++) begin
            applyStimulus($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 2), 1'b0);
            if (i == 254) checkOutput("wrap_255", 32'(cmd_count), 32'd255);
            if (i == 255) checkOutput("wrap_0", 32'(cmd_count), 32'd0);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
